// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller and the PC register.
// FSM state encoding and the fixed handler entry address.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } int_state_t;

    localparam logic [31:0] INT_VECTOR = 32'h1C09_0000;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line.
// Asynchronous active-low reset clears both stages.
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Single-level interrupt controller: edge detect, priority select, EPC capture.
// Define INT_CTRL_SYNC_EN to put a 2-flop synchronizer on every irq line.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic [31:0]                new_pc,
    input  logic                       eret,
    input  logic                       cfg_we,
    input  logic [NUM_IRQ:0]           cfg_wdata,
    output logic                       int_req,
    output logic [31:0]                epc,
    output logic [$clog2(NUM_IRQ)-1:0] cause,
    output logic                       in_service,
    output logic [NUM_IRQ-1:0]         pending,
    output logic [NUM_IRQ-1:0]         mask,
    output logic                       gie
);

    localparam int CW = $clog2(NUM_IRQ);

    int_state_t state, state_nx;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] claim;
    logic [CW-1:0]      sel_idx;
    logic               take;

`ifdef INT_CTRL_SYNC_EN
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        int_sync u_sync (
            .clk (clk),
            .rst (rst),
            .d   (irq[g]),
            .q   (irq_s[g])
        );
    end
`else
    assign irq_s = irq;
`endif

    assign rise     = irq_s & ~irq_d;
    assign eligible = gie ? (pending & mask) : '0;
    assign take     = (state == ST_IDLE) && (|eligible);

    // Isolate the lowest set bit of the eligible vector.
    assign claim = take ? (eligible & (~eligible + 1'b1)) : '0;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel_idx = CW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d   <= '0;
            pending <= '0;
            mask    <= '0;
            gie     <= 1'b0;
        end else begin
            irq_d   <= irq_s;
            // A fresh edge on the line being claimed keeps it pending.
            pending <= (pending & ~claim) | rise;
            if (cfg_we) begin
                mask <= cfg_wdata[NUM_IRQ-1:0];
                gie  <= cfg_wdata[NUM_IRQ];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause <= '0;
            epc   <= '0;
        end else begin
            if (take) cause <= sel_idx;
            if (state == ST_REQ) epc <= new_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (take) state_nx = ST_REQ;
            ST_REQ:  state_nx = ST_SVC;
            ST_SVC:  if (eret) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        int_req    = 1'b0;
        in_service = 1'b0;
        unique case (1'b1)
            (state == ST_REQ): int_req    = 1'b1;
            (state == ST_SVC): in_service = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (NUM_IRQ = 8).
// Latencies follow INT_CTRL_SYNC_EN when it is defined for the build.
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic [31:0] new_pc;
    logic        eret;
    logic        cfg_we;
    logic [8:0]  cfg_wdata;
    logic        int_req;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        in_service;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic        gie;

    int errors = 0;
    int checks = 0;
    int int_cnt = 0;
    int c0;

    int_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .new_pc     (new_pc),
        .eret       (eret),
        .cfg_we     (cfg_we),
        .cfg_wdata  (cfg_wdata),
        .int_req    (int_req),
        .epc        (epc),
        .cause      (cause),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask),
        .gie        (gie)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (int_req === 1'b1) int_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic g, input logic [7:0] m);
        cfg_wdata = {g, m};
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic finish_svc();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        rst = 1'b0; irq = '0; new_pc = '0; eret = 1'b0;
        cfg_we = 1'b0; cfg_wdata = '0;
        #12;
        chk("rst_int", 32'(int_req), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_cause", 32'(cause), 0);
        tick();
        rst = 1'b1;
        tick();
        cfg(1'b1, 8'hFF);
        chk("cfg_gie", 32'(gie), 1);
        chk("cfg_mask", 32'(mask), 32'hFF);

        // single pulse on line 3
        new_pc = 32'h0000_0040;
        irq = 8'h08; tick(); irq = '0;
        repeat (LAT) tick();
        chk("p3_pend", 32'(pending[3]), 1);
        chk("p3_noint", 32'(int_req), 0);
        tick();
        chk("p3_int", 32'(int_req), 1);
        chk("p3_cause", 32'(cause), 3);
        chk("p3_clr", 32'(pending[3]), 0);
        tick();
        chk("p3_int1cyc", 32'(int_req), 0);
        chk("p3_svc", 32'(in_service), 1);
        chk("p3_epc", epc, 32'h0000_0040);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("p3_eret", 32'(in_service), 0);

        // lines 5 and 2 together
        irq = 8'h24; tick(); irq = '0;
        repeat (LAT) tick();
        chk("p25_pend", 32'(pending), 32'h24);
        tick();
        chk("p25_int_a", 32'(int_req), 1);
        chk("p25_cause_a", 32'(cause), 2);
        chk("p25_pend_a", 32'(pending), 32'h20);
        tick();
        finish_svc();
        chk("p25_idle_int", 32'(int_req), 0);
        chk("p25_idle_svc", 32'(in_service), 0);
        tick();
        chk("p25_int_b", 32'(int_req), 1);
        chk("p25_cause_b", 32'(cause), 5);
        tick();
        finish_svc();

        // masked line, then unmask
        cfg(1'b1, 8'h00);
        c0 = int_cnt;
        irq = 8'h02; tick(); irq = '0;
        repeat (LAT + 3) tick();
        chk("m1_noint", 32'(int_cnt - c0), 0);
        chk("m1_pend", 32'(pending[1]), 1);
        cfg(1'b1, 8'h02);
        tick();
        chk("m1_int", 32'(int_req), 1);
        chk("m1_cause", 32'(cause), 1);
        tick();
        finish_svc();

        // global disable holds the bit
        cfg(1'b0, 8'hFF);
        c0 = int_cnt;
        irq = 8'h40; tick(); irq = '0;
        repeat (LAT + 3) tick();
        chk("g6_noint", 32'(int_cnt - c0), 0);
        chk("g6_pend", 32'(pending[6]), 1);
        cfg(1'b1, 8'hFF);
        tick();
        chk("g6_cause", 32'(cause), 6);
        chk("g6_int", 32'(int_req), 1);
        tick();
        finish_svc();

        // new edge on the same edge that claims the line
        cfg(1'b0, 8'hFF);
        irq = 8'h08; tick(); irq = '0;
        repeat (LAT + 2) tick();
        chk("sw_pend0", 32'(pending[3]), 1);
        if (LAT == 0) begin
            cfg(1'b1, 8'hFF);
            irq = 8'h08; tick(); irq = '0;
        end else begin
            irq = 8'h08; tick(); irq = '0;
            cfg(1'b1, 8'hFF);
            tick();
        end
        chk("sw_int", 32'(int_req), 1);
        chk("sw_cause", 32'(cause), 3);
        chk("sw_keep", 32'(pending[3]), 1);
        tick();
        finish_svc();
        tick();
        chk("sw_int2", 32'(int_req), 1);
        chk("sw_pend1", 32'(pending[3]), 0);
        tick();
        finish_svc();

        // line 0 held high across two handlers
        c0 = int_cnt;
        irq = 8'h01; tick();
        repeat (LAT) tick();
        tick();
        chk("h0_cause", 32'(cause), 0);
        tick();
        finish_svc();
        repeat (4) tick();
        irq = 8'h81; tick(); irq = 8'h01;
        repeat (LAT) tick();
        tick();
        chk("h0_cause7", 32'(cause), 7);
        tick();
        finish_svc();
        repeat (4) tick();
        chk("h0_count", 32'(int_cnt - c0), 2);
        chk("h0_pend", 32'(pending), 0);
        irq = '0;
        repeat (LAT + 2) tick();

        // edge arriving with eret in service
        irq = 8'h02; tick(); irq = '0;
        repeat (LAT) tick();
        tick();
        tick();
        chk("e4_svc", 32'(in_service), 1);
        irq = 8'h10; eret = 1'b1;
        tick();
        irq = '0; eret = 1'b0;
        chk("e4_idle", 32'(in_service), 0);
        repeat (LAT) tick();
        chk("e4_pend", 32'(pending[4]), 1);
        tick();
        chk("e4_int", 32'(int_req), 1);
        chk("e4_cause", 32'(cause), 4);
        tick();
        finish_svc();

        // reset in the middle of a request
        new_pc = 32'h0000_1234;
        irq = 8'h04; tick(); irq = '0;
        repeat (LAT) tick();
        tick();
        chk("r_int_pre", 32'(int_req), 1);
        #2 rst = 1'b0;
        #1;
        chk("r_int", 32'(int_req), 0);
        chk("r_epc", epc, 0);
        chk("r_cause", 32'(cause), 0);
        chk("r_svc", 32'(in_service), 0);
        chk("r_pend", 32'(pending), 0);
        chk("r_cfg", 32'({gie, mask}), 0);
        tick();
        rst = 1'b1;
        cfg(1'b1, 8'hFF);
        c0 = int_cnt;
        repeat (6) tick();
        chk("r_noint", 32'(int_cnt - c0), 0);
        chk("r_pend_after", 32'(pending), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: NUM_IRQ, default 8, number of interrupt sources (legal 2..32).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 irq  input  NUM_IRQ  external interrupt lines, asynchronous to clk.
REQ-005 new_pc  input  32  next-PC value from datapath, captured as return address.
REQ-006 eret  input  1  return-from-handler instruction retired this cycle.
REQ-007 cfg_we  input  1  configuration write strobe.
REQ-008 cfg_wdata  input  NUM_IRQ+1  bit NUM_IRQ = global enable, low bits = per-line mask (1 = enabled).
REQ-009 int  output  1  redirect request to PC register, high exactly one cycle per taken interrupt.
REQ-010 epc  output  32  captured return address.
REQ-011 cause  output  $clog2(NUM_IRQ)  index of interrupt being serviced.
REQ-012 in_service  output  1  handler active.
REQ-013 pending, mask  output  NUM_IRQ each; gie  output  1  -- register readback.

Function
REQ-014 Edge detect: pending[i] SHALL set on a 0->1 transition of synchronized irq[i]; a held-high line SHALL not re-set it.
REQ-015 Eligible set = pending & mask, only when gie=1; selection SHALL be lowest eligible index.
REQ-016 FSM states IDLE, REQ, SVC; IDLE->REQ when eligible set non-zero, registering cause and clearing the selected pending bit on that edge.
REQ-017 int SHALL be high iff state==REQ; REQ->SVC unconditionally after one cycle.
REQ-018 On the REQ->SVC edge, epc SHALL load new_pc.
REQ-019 in_service SHALL be high iff state==SVC; SVC->IDLE on eret=1.
REQ-020 eret in IDLE or REQ SHALL be ignored; no nesting -- new edges during REQ/SVC only accumulate in pending.
REQ-021 Same-cycle set and claim-clear on one pending bit: set wins (bit remains 1).
REQ-022 Minimum one IDLE cycle between eret and next int.
REQ-023 cfg_we updates mask/gie at the edge; takes effect on next IDLE selection; never cancels a REQ in flight.
REQ-024 Masked or gie=0 pending bits SHALL persist until claimed.
REQ-025 Latency (sync enabled): irq rising before edge k -> pending at edge k+2 -> REQ at edge k+3 -> int high cycle k+3..k+4.

Reset
REQ-026 rst low SHALL immediately force IDLE, int=0, epc=0, cause=0, in_service=0, pending=0, mask=0, gie=0, synchronizer and edge-history flops=0, including mid-REQ or mid-SVC.

Configuration
REQ-027 Macro INT_CTRL_SYNC_EN defined: each irq line passes a 2-flop synchronizer before edge detect.
REQ-028 INT_CTRL_SYNC_EN undefined: irq sampled directly by edge-history flop; all latencies in REQ-025 shrink by 2 cycles.

Structure
REQ-029 Shared package holds FSM state encoding (IDLE/REQ/SVC) and the interrupt vector constant 32'h1C09_0000 used by the PC register.
REQ-030 One sub-module: int_sync (per-line 2-flop synchronizer, async active-low reset), instantiated NUM_IRQ times under INT_CTRL_SYNC_EN.

Verification
REQ-031 gie=1, mask=8'hFF, pulse irq[3], new_pc=32'h0000_0040 -> int one cycle, cause=3, epc=32'h0000_0040, in_service=1, pending[3]=0.
REQ-032 irq[5] and irq[2] rise same cycle -> cause=2 served first; after eret, one IDLE cycle, then int with cause=5.
REQ-033 mask=8'h00, pulse irq[1] -> no int, pending[1]=1; write mask=8'h02 -> int with cause=1.
REQ-034 irq[0] held high through two handlers -> only one pending set, one int.
REQ-035 rst asserted while state==REQ -> int drops immediately, all outputs 0; after release no int without a new edge.
REQ-036 In SVC, pulse irq[4], eret same cycle as pulse -> pending[4]=1, returns to IDLE, then int with cause=4.
